// File: rtl/pulse_note_scheduler.sv
// ============================================================================
// pulse_note_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//   Note sequencer for the square-wave pulse channel. Note commands
//   {phase_delta, volume, duration} arrive over a valid/ready handshake into a
//   small synchronous FIFO. Each note is played with an attack / sustain /
//   release envelope that advances only on frame-tick cycles. The scheduler
//   drives the channel's phase increment and 9-bit envelope (0..256).
//
// Ports:
//   i_clk               system clock
//   i_reset             asynchronous, active-high reset
//   i_tick              one-cycle frame strobe; all envelope/duration stepping
//   i_note_valid        note command present
//   o_note_ready        queue can accept a note (not full)
//   i_note_phase_delta  phase increment of the note
//   i_note_volume       sustain level, values above 256 saturate to 256
//   i_note_duration     sustain length in ticks (N gives N+1 sustain ticks)
//   o_phase_delta       phase increment to the phase generator
//   o_envelope          amplitude to the pulse compare
//   o_busy              note in progress or queue non-empty
//   o_note_done         one-cycle pulse when a note finishes
//
// Configuration:
//   PULSE_SCHED_LEGATO_EN  when defined, a note whose sustain ends while
//                          another note is queued skips its release; the next
//                          note ramps from the current envelope level.
// ============================================================================
module pulse_note_scheduler #(
    parameter int unsigned FIFO_DEPTH   = 4,       // power of two, 2..16
    parameter logic [8:0]  ATTACK_STEP  = 9'd32,
    parameter logic [8:0]  RELEASE_STEP = 9'd16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic        i_note_valid,
    output logic        o_note_ready,
    input  logic [31:0] i_note_phase_delta,
    input  logic [8:0]  i_note_volume,
    input  logic [7:0]  i_note_duration,
    output logic [31:0] o_phase_delta,
    output logic [8:0]  o_envelope,
    output logic        o_busy,
    output logic        o_note_done
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [8:0]  VOL_MAX = 9'd256;

    typedef struct packed {
        logic [31:0] delta;
        logic [8:0]  volume;
        logic [7:0]  duration;
    } note_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    // ---------------------------------------------------------------- queue
    note_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    note_t            head;

    // ------------------------------------------------------ note / envelope
    state_t      state_q, state_d;
    logic [31:0] delta_q, delta_d;
    logic [8:0]  vol_q, vol_d;
    logic [7:0]  dur_q, dur_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  env_q, env_d;
    logic        done_q, done_d;

    logic [9:0]  attack_sum;
    logic [8:0]  attack_env;
    logic [8:0]  release_env;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign o_note_ready = !fifo_full;
    assign push         = i_note_valid && !fifo_full;
    assign head         = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; an entry is only read after
    // count_q shows it was written, so a reset would add nothing but cost.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{delta:    i_note_phase_delta,
                                 volume:   i_note_volume,
                                 duration: i_note_duration};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Envelope arithmetic is done one bit wider so the attack ramp can never
    // wrap past 511 before being clamped to the note volume.
    assign attack_sum  = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    assign attack_env  = (attack_sum >= {1'b0, vol_q}) ? vol_q : attack_sum[8:0];
    assign release_env = (env_q > RELEASE_STEP) ? (env_q - RELEASE_STEP) : '0;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        delta_d = delta_q;
        vol_d   = vol_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        env_d   = env_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                env_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end

            // One clock of latency; ticks are ignored here. A zero volume is a
            // rest note and goes straight to sustain at the current level.
            S_LOAD: begin
                if (vol_q == '0) begin
                    cnt_d   = dur_q;
                    state_d = S_SUSTAIN;
                end else begin
                    state_d = S_ATTACK;
                end
            end

            S_ATTACK: begin
                if (i_tick) begin
                    env_d = attack_env;
                    if (attack_env == vol_q) begin
                        cnt_d   = dur_q;
                        state_d = S_SUSTAIN;
                    end
                end
            end

            // The tick that finds the counter at zero ends sustain, so a
            // duration of N holds the level for N+1 ticks.
            S_SUSTAIN: begin
                if (i_tick) begin
                    if (cnt_q == '0) begin
`ifdef PULSE_SCHED_LEGATO_EN
                        if (!fifo_empty) begin
                            done_d  = 1'b1;
                            pop     = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_RELEASE;
                        end
`else
                        state_d = S_RELEASE;
`endif
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_RELEASE: begin
                if (i_tick) begin
                    env_d = release_env;
                    if (release_env == '0) begin
                        done_d = 1'b1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // The head entry is captured on the pop edge, so the note registers
        // already hold the new note throughout LOAD.
        if (pop) begin
            delta_d = head.delta;
            vol_d   = (head.volume > VOL_MAX) ? VOL_MAX : head.volume;
            dur_d   = head.duration;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            delta_q  <= '0;
            vol_q    <= '0;
            dur_q    <= '0;
            cnt_q    <= '0;
            env_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            state_q <= state_d;
            delta_q <= delta_d;
            vol_q   <= vol_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            env_q   <= env_d;
            done_q  <= done_d;
        end
    end

    assign o_phase_delta = (state_q == S_ATTACK || state_q == S_SUSTAIN ||
                            state_q == S_RELEASE) ? delta_q : '0;
    assign o_envelope    = env_q;
    assign o_busy        = (state_q != S_IDLE) || !fifo_empty;
    assign o_note_done   = done_q;

endmodule

// File: tb/tb_pulse_note_scheduler.sv
// ============================================================================
// tb_pulse_note_scheduler
// ----------------------------------------------------------------------------
// Self-checking bench for pulse_note_scheduler. Ticks arrive every 10 clocks
// so each tick produces exactly one envelope step. A reference model expands
// each note into its per-tick envelope sequence; every tick the DUT envelope,
// done pulse and phase delta are compared against that sequence.
// ============================================================================
`timescale 1ns/1ps
module tb_pulse_note_scheduler;

    localparam int DEPTH = 4;
    localparam int ATK   = 32;
    localparam int REL   = 16;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_tick = 1'b0;
    logic        i_note_valid = 1'b0;
    logic        o_note_ready;
    logic [31:0] i_note_phase_delta = '0;
    logic [8:0]  i_note_volume = '0;
    logic [7:0]  i_note_duration = '0;
    logic [31:0] o_phase_delta;
    logic [8:0]  o_envelope;
    logic        o_busy;
    logic        o_note_done;

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    // One expected observation per tick of a note.
    typedef struct {
        int          env;
        logic [31:0] phase;
        bit          last;
    } exp_t;
    exp_t exp_q[$];

    pulse_note_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_tick             (i_tick),
        .i_note_valid       (i_note_valid),
        .o_note_ready       (o_note_ready),
        .i_note_phase_delta (i_note_phase_delta),
        .i_note_volume      (i_note_volume),
        .i_note_duration    (i_note_duration),
        .o_phase_delta      (o_phase_delta),
        .o_envelope         (o_envelope),
        .o_busy             (o_busy),
        .o_note_done        (o_note_done)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_note_done === 1'b1) done_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------- reference model
    // Expands one note into the envelope seen after each tick it occupies:
    // ramp up by ATK to the saturated volume, hold for dur+1 ticks, then fall
    // by REL to zero. A rest note holds 0 and takes one release tick.
    function automatic void model_note(input logic [31:0] delta, input int vol, input int dur);
        int   v;
        int   e;
        exp_t x;
        v       = (vol > 256) ? 256 : vol;
        x.phase = delta;
        x.last  = 1'b0;
        e       = 0;
        while (e < v) begin
            e     = (e + ATK > v) ? v : e + ATK;
            x.env = e;
            exp_q.push_back(x);
        end
        for (int i = 0; i <= dur; i++) begin
            x.env = v;
            exp_q.push_back(x);
        end
        if (v == 0) begin
            x.env  = 0;
            x.last = 1'b1;
            exp_q.push_back(x);
        end else begin
            while (e > 0) begin
                e      = (e > REL) ? e - REL : 0;
                x.env  = e;
                x.last = (e == 0);
                exp_q.push_back(x);
            end
        end
    endfunction

    // ------------------------------------------------------------- drivers
    // Called and returns at a falling edge.
    task automatic tick_sample(output logic [8:0] env, output logic [31:0] ph, output logic dn);
        repeat (9) @(negedge i_clk);
        i_tick = 1'b1;
        @(negedge i_clk);
        i_tick = 1'b0;
        env = o_envelope;
        ph  = o_phase_delta;
        dn  = o_note_done;
    endtask

    task automatic push_note(input logic [31:0] d, input logic [8:0] v, input logic [7:0] dur,
                             output bit ok);
        int waited = 0;
        i_note_valid       = 1'b1;
        i_note_phase_delta = d;
        i_note_volume      = v;
        i_note_duration    = dur;
        while (o_note_ready !== 1'b1 && waited < 2000) begin
            @(negedge i_clk);
            waited++;
        end
        ok = (o_note_ready === 1'b1);
        @(negedge i_clk);
        i_note_valid = 1'b0;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        #1 i_reset = 1'b1;
        #2;
        checks++; if (o_envelope !== 9'd0)     begin errors++; $display("FAIL reset_env: got %0d expected 0", o_envelope); end
        checks++; if (o_phase_delta !== 32'd0) begin errors++; $display("FAIL reset_phase: got %h expected 0", o_phase_delta); end
        checks++; if (o_busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_note_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b expected 1", o_note_ready); end
        checks++; if (o_note_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", o_note_done); end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_single_note();
        int          d0 = done_count;
        int          t = 0;
        bit          ok;
        exp_t        x;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        exp_q.delete();
        model_note(32'h0100_0000, 256, 2);
        push_note(32'h0100_0000, 9'd256, 8'd2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_push: got not accepted expected accepted"); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy_on: got %b expected 1", o_busy); end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tick_sample(env, ph, dn);
            checks++; if (env !== 9'(x.env)) begin errors++; $display("FAIL single_env tick %0d: got %0d expected %0d", t, env, x.env); end
            checks++; if (dn !== logic'(x.last)) begin errors++; $display("FAIL single_done tick %0d: got %b expected %b", t, dn, x.last); end
            if (!x.last) begin
                checks++; if (ph !== x.phase) begin errors++; $display("FAIL single_phase tick %0d: got %h expected %h", t, ph, x.phase); end
            end
            t++;
        end
        repeat (2) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_off: got %b expected 0", o_busy); end
        checks++; if (o_phase_delta !== 32'd0) begin errors++; $display("FAIL single_idle_phase: got %h expected 0", o_phase_delta); end
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_count - d0); end
    endtask

    task automatic test_rest_note();
        int          d0 = done_count;
        int          t = 0;
        bit          ok;
        exp_t        x;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        exp_q.delete();
        model_note(32'h00AB_CDEF, 0, 3);
        push_note(32'h00AB_CDEF, 9'd0, 8'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rest_push: got not accepted expected accepted"); end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tick_sample(env, ph, dn);
            checks++; if (env !== 9'(x.env)) begin errors++; $display("FAIL rest_env tick %0d: got %0d expected %0d", t, env, x.env); end
            checks++; if (dn !== logic'(x.last)) begin errors++; $display("FAIL rest_done tick %0d: got %b expected %b", t, dn, x.last); end
            if (!x.last) begin
                checks++; if (ph !== x.phase) begin errors++; $display("FAIL rest_phase tick %0d: got %h expected %h", t, ph, x.phase); end
            end
            t++;
        end
        repeat (2) @(negedge i_clk);
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL rest_done_count: got %0d expected 1", done_count - d0); end
    endtask

    // Volume 300 saturates to 256; volume 40 ramps 32, 40.
    task automatic test_volume_clamp();
        int          d0 = done_count;
        int          t = 0;
        bit          ok;
        exp_t        x;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        logic [8:0]  vols [2];
        vols[0] = 9'd300;
        vols[1] = 9'd40;
        for (int n = 0; n < 2; n++) begin
            exp_q.delete();
            model_note(32'h0020_0000 + 32'(n), int'(vols[n]), 1);
            push_note(32'h0020_0000 + 32'(n), vols[n], 8'd1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL clamp_push %0d: got not accepted expected accepted", n); end
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tick_sample(env, ph, dn);
                checks++; if (env !== 9'(x.env)) begin errors++; $display("FAIL clamp_env note %0d tick %0d: got %0d expected %0d", n, t, env, x.env); end
                checks++; if (dn !== logic'(x.last)) begin errors++; $display("FAIL clamp_done note %0d tick %0d: got %b expected %b", n, t, dn, x.last); end
                t++;
            end
            repeat (2) @(negedge i_clk);
        end
        checks++; if (done_count - d0 != 2) begin errors++; $display("FAIL clamp_done_count: got %0d expected 2", done_count - d0); end
    endtask

`ifndef PULSE_SCHED_LEGATO_EN
    // One note playing, then five more pushed: four fill the queue, the fifth
    // waits for the first pop. All six must play in push order.
    task automatic test_back_to_back();
        int          d0 = done_count;
        int          t = 0;
        int          done_at_b5 = 0;
        bit          ok;
        bit          ok5 = 1'b0;
        bit          full_seen = 1'b0;
        exp_t        x;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        exp_q.delete();
        model_note(32'h0000_1000, 64, 0);
        for (int i = 1; i <= 5; i++) model_note(32'h0000_1000 * 32'(i + 1), 20 * i + 10, 0);
        push_note(32'h0000_1000, 9'd64, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_push_a: got not accepted expected accepted"); end
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    push_note(32'h0000_1000 * 32'(i + 1), 9'(20 * i + 10), 8'd0, ok);
                    checks++; if (!ok) begin errors++; $display("FAIL b2b_push %0d: got not accepted expected accepted", i); end
                end
                full_seen = (o_note_ready === 1'b0);
                push_note(32'h0000_6000, 9'd110, 8'd0, ok5);
                done_at_b5 = done_count - d0;
            end
            begin
                while (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    tick_sample(env, ph, dn);
                    checks++; if (env !== 9'(x.env)) begin errors++; $display("FAIL b2b_env tick %0d: got %0d expected %0d", t, env, x.env); end
                    checks++; if (dn !== logic'(x.last)) begin errors++; $display("FAIL b2b_done tick %0d: got %b expected %b", t, dn, x.last); end
                    if (!x.last) begin
                        checks++; if (ph !== x.phase) begin errors++; $display("FAIL b2b_phase tick %0d: got %h expected %h", t, ph, x.phase); end
                    end
                    t++;
                end
            end
        join
        checks++; if (!full_seen) begin errors++; $display("FAIL b2b_ready_full: got ready=1 expected ready=0 after 4 queued"); end
        checks++; if (!ok5) begin errors++; $display("FAIL b2b_push_5: got not accepted expected accepted"); end
        checks++; if (done_at_b5 != 1) begin errors++; $display("FAIL b2b_5th_timing: got %0d notes done at accept expected 1", done_at_b5); end
        repeat (2) @(negedge i_clk);
        checks++; if (done_count - d0 != 6) begin errors++; $display("FAIL b2b_done_count: got %0d expected 6", done_count - d0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_off: got %b expected 0", o_busy); end
    endtask

    task automatic test_random_notes();
        int          d0 = done_count;
        int          t = 0;
        bit          ok;
        exp_t        x;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        logic [31:0] rd;
        int          rv;
        int          rdur;
        for (int round = 0; round < 2; round++) begin
            exp_q.delete();
            for (int n = 0; n < 4; n++) begin
                rd   = $urandom;
                rv   = $urandom_range(0, 320);
                rdur = $urandom_range(0, 3);
                model_note(rd, rv, rdur);
                push_note(rd, 9'(rv), 8'(rdur), ok);
                checks++; if (!ok) begin errors++; $display("FAIL rand_push r%0d n%0d: got not accepted expected accepted", round, n); end
            end
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tick_sample(env, ph, dn);
                checks++; if (env !== 9'(x.env)) begin errors++; $display("FAIL rand_env tick %0d: got %0d expected %0d", t, env, x.env); end
                checks++; if (dn !== logic'(x.last)) begin errors++; $display("FAIL rand_done tick %0d: got %b expected %b", t, dn, x.last); end
                if (!x.last) begin
                    checks++; if (ph !== x.phase) begin errors++; $display("FAIL rand_phase tick %0d: got %h expected %h", t, ph, x.phase); end
                end
                t++;
            end
            repeat (2) @(negedge i_clk);
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rand_busy_off r%0d: got %b expected 0", round, o_busy); end
        end
        checks++; if (done_count - d0 != 8) begin errors++; $display("FAIL rand_done_count: got %0d expected 8", done_count - d0); end
    endtask
`else
    // Two queued notes: no release between them, note 2's first attack tick
    // clamps 256 down to 128, two done pulses.
    task automatic test_legato();
        int          d0 = done_count;
        int          t = 0;
        bit          ok;
        exp_t        x;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        exp_q.delete();
        x.last  = 1'b0;
        x.phase = 32'h0111_0000;
        for (int k = 1; k <= 8; k++) begin x.env = 32 * k; exp_q.push_back(x); end
        x.env = 256; x.last = 1'b1; exp_q.push_back(x);
        x.phase = 32'h0222_0000; x.last = 1'b0;
        x.env = 128; exp_q.push_back(x);
        x.env = 128; exp_q.push_back(x);
        for (int e = 112; e >= 0; e -= 16) begin x.env = e; x.last = (e == 0); exp_q.push_back(x); end
        push_note(32'h0111_0000, 9'd256, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL legato_push1: got not accepted expected accepted"); end
        push_note(32'h0222_0000, 9'd128, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL legato_push2: got not accepted expected accepted"); end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tick_sample(env, ph, dn);
            checks++; if (env !== 9'(x.env)) begin errors++; $display("FAIL legato_env tick %0d: got %0d expected %0d", t, env, x.env); end
            checks++; if (dn !== logic'(x.last)) begin errors++; $display("FAIL legato_done tick %0d: got %b expected %b", t, dn, x.last); end
            if (!x.last) begin
                checks++; if (ph !== x.phase) begin errors++; $display("FAIL legato_phase tick %0d: got %h expected %h", t, ph, x.phase); end
            end
            t++;
        end
        repeat (2) @(negedge i_clk);
        checks++; if (done_count - d0 != 2) begin errors++; $display("FAIL legato_done_count: got %0d expected 2", done_count - d0); end
    endtask
`endif

    // Reset asserted between clock edges mid-note with notes queued.
    task automatic test_reset_mid_note();
        int          d0;
        bit          ok;
        logic [8:0]  env;
        logic [31:0] ph;
        logic        dn;
        for (int n = 0; n < 3; n++) begin
            push_note(32'h0300_0000, 9'd200, 8'd5, ok);
            checks++; if (!ok) begin errors++; $display("FAIL midrst_push %0d: got not accepted expected accepted", n); end
        end
        repeat (3) tick_sample(env, ph, dn);
        checks++; if (env !== 9'd96) begin errors++; $display("FAIL midrst_pre_env: got %0d expected 96", env); end
        d0 = done_count;
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        checks++; if (o_envelope !== 9'd0)     begin errors++; $display("FAIL midrst_env: got %0d expected 0", o_envelope); end
        checks++; if (o_phase_delta !== 32'd0) begin errors++; $display("FAIL midrst_phase: got %h expected 0", o_phase_delta); end
        checks++; if (o_busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
        checks++; if (o_note_ready !== 1'b1)   begin errors++; $display("FAIL midrst_ready: got %b expected 1", o_note_ready); end
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (2) tick_sample(env, ph, dn);
        checks++; if (env !== 9'd0)     begin errors++; $display("FAIL midrst_after_env: got %0d expected 0", env); end
        checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL midrst_after_busy: got %b expected 0 (queue discarded)", o_busy); end
        checks++; if (done_count != d0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_count - d0); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_rest_note();
        test_volume_clamp();
`ifndef PULSE_SCHED_LEGATO_EN
        test_back_to_back();
        test_random_notes();
`else
        test_legato();
`endif
        test_reset_mid_note();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_note_scheduler.md
Name: pulse_note_scheduler

Overview:
- Sequences the square-wave pulse channel: accepts queued note commands over a valid/ready handshake.
- Drives the channel's phase-delta and 9-bit envelope inputs.
- Runs a per-note attack/sustain/release envelope stepped by a frame tick (e.g. 60 Hz strobe).
- Replaces the hard-wired note ROM sequencer so the song source, whether CPU, UART loader or ROM walker, can feed notes at runtime.

Parameters:
- FIFO_DEPTH, 4, note queue entries; power of two, 2..16.
- ATTACK_STEP, 9'd32, envelope increment per tick in ATTACK.
- RELEASE_STEP, 9'd16, envelope decrement per tick in RELEASE.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_tick  in  1  one-cycle frame strobe; all envelope and duration stepping happens only on cycles with i_tick=1.
- i_note_valid  in  1  note command present.
- o_note_ready  out  1  queue can accept a note.
- i_note_phase_delta  in  32  phase increment for the phase generator.
- i_note_volume  in  9  sustain level; values >256 saturate to 256.
- i_note_duration  in  8  sustain length in ticks.
- o_phase_delta  out  32  to the phase generator.
- o_envelope  out  9  amplitude for the pulse compare.
- o_busy  out  1  a note is in progress or the queue is non-empty.
- o_note_done  out  1  one-cycle pulse when a note completes release or is cut.

Behaviour:
- Reset (async assert, sync release) values:
  - o_phase_delta=0, o_envelope=0, o_note_done=0, o_busy=0, o_note_ready=1.
  - Queue empty, state IDLE.
- Queue:
  - Synchronous FIFO of {phase_delta, volume, duration}.
  - o_note_ready = !full, registered-free combinational from count.
  - Push occurs when i_note_valid && o_note_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Valid while full is stalled and no data is lost; the source must hold its data.
- States: IDLE, LOAD, ATTACK, SUSTAIN, RELEASE.
- IDLE:
  - o_envelope=0, o_phase_delta=0.
  - If the queue is non-empty, pop and go to LOAD on the next cycle.
- LOAD (exactly 1 cycle):
  - Latch the popped entry into the note registers.
  - o_phase_delta takes the note value from the following cycle.
  - Envelope is unchanged; i_tick is ignored.
  - Go to ATTACK. If volume is 0 (rest note), go to SUSTAIN instead.
- ATTACK: on each tick, env = min(env+ATTACK_STEP, volume), computed 10-bit with no wrap. On the tick where env reaches volume, go to SUSTAIN with the duration counter loaded to the note's duration.
- SUSTAIN:
  - Envelope is held.
  - Each tick decrements the counter.
  - Leave to RELEASE on the tick that sees counter==0. Duration 0 therefore gives a 1-tick sustain; duration N gives N+1 ticks.
- RELEASE:
  - Each tick sets env = (env>RELEASE_STEP) ? env-RELEASE_STEP : 0.
  - When env==0 after the update, pulse o_note_done for 1 cycle.
  - Then go to LOAD if the queue is non-empty, otherwise IDLE.
  - o_phase_delta holds the note value through RELEASE.
- o_busy = (state!=IDLE) || !empty.
- Reset mid-note: all outputs return immediately to reset values and queue contents are discarded.
- Throughput: at most one note transition per tick boundary; LOAD adds 1 clock of latency, not 1 tick.

Optional Feature:
- Macro: PULSE_SCHED_LEGATO_EN.
- Defined: when SUSTAIN would exit and the queue is non-empty, RELEASE is skipped.
  - o_note_done pulses for 1 cycle and the state goes to LOAD.
  - The envelope is NOT reset; the next ATTACK ramps from the current level.
  - If the current level is greater than the new volume, the first ATTACK tick clamps env to the new volume.
- Undefined: every note releases fully to 0 before the next note loads.

Test Plan:
- Reset with notes queued → o_envelope=0, o_phase_delta=0, o_busy=0, o_note_ready=1 asynchronously, before any clock edge.
- Push {delta=0x0100_0000, vol=256, dur=2}, tick every 10 clocks:
  - envelope 32,64,…,256 over 8 ticks.
  - Held 256 for 3 ticks.
  - Then 240,224,…,0 over 16 ticks.
  - o_note_done pulses once; o_busy falls.
- Push 5 notes back-to-back with FIFO_DEPTH=4 and the scheduler busy → o_note_ready low after 4 accepted; 5th held until the first pop, then accepted; all 5 play in order.
- Rest note {vol=0, dur=3} → envelope stays 0, phase_delta loaded, done pulse after 4 sustain ticks plus 1 release tick.
- vol=300 → sustain level 256; vol=40 → attack 32,40 then sustain 40.
- With PULSE_SCHED_LEGATO_EN: two queued notes vol 256 then 128 → no release between them; envelope goes 256→128 on the first ATTACK tick of note 2; two done pulses.
